led_scan_controller: RTL

- Time-multiplexed scan controller for the 4-digit common-anode 7-segment display.
- Sequences one LEDdecoder instance across all digits: presents one 4-bit hex nibble per time slot and drives the active-low anode strobes.
- Guard intervals keep anodes off around each nibble change, which prevents ghosting.
- Host updates are double-buffered and committed only at frame boundaries, so a displayed frame never mixes old and new digits.

---
 rtl/led_scan_controller.sv | 106 ++++++++++
 1 files changed

// File: rtl/led_scan_controller.sv
// ============================================================================
// Module   : led_scan_controller
// Purpose  : 4-digit common-anode 7-segment scan sequencer with guard bands
//            and frame-aligned double-buffered message updates.
// Option   : LED_SCAN_BLANK_LEADING_EN enables leading-zero suppression.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_scan_controller #(
  parameter int SLOT_CYCLES  = 16,
  parameter int GUARD_CYCLES = 2,
  parameter int DIGITS       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [15:0]       message,
  input  logic              load,
  output logic              load_pending,
  output logic [3:0]        nibble,
  output logic [DIGITS-1:0] an,
  output logic              frame_done
);

  localparam int              c_CW   = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(SLOT_CYCLES - 1);

  logic [c_CW-1:0]   r_cnt;
  logic [1:0]        r_dig;
  logic [15:0]       r_shadow;
  logic [15:0]       r_display;

  logic              w_slot_end;
  logic              w_frame_end;
  logic              w_lit_phase;
  logic              w_blank;
  logic [3:0]        w_digit_nib;
  logic [DIGITS-1:0] w_an_next;

  assign w_slot_end  = (r_cnt == c_LAST);
  assign w_frame_end = w_slot_end && (r_dig == 2'd0);
  assign w_lit_phase = (int'(r_cnt) >= GUARD_CYCLES) &&
                       (int'(r_cnt) <  SLOT_CYCLES - GUARD_CYCLES);
  assign w_digit_nib = r_display[{r_dig, 2'b00} +: 4];

`ifdef LED_SCAN_BLANK_LEADING_EN
  // A digit stays dark while it and every digit to its left are zero.
  always_comb begin
    w_blank = 1'b0;
    case (r_dig)
      2'd3:    w_blank = (r_display[15:12] == 4'h0);
      2'd2:    w_blank = (r_display[15:8]  == 8'h00);
      2'd1:    w_blank = (r_display[15:4]  == 12'h000);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  assign w_an_next = (w_lit_phase && !w_blank) ? ~(DIGITS'(1) << r_dig)
                                               : {DIGITS{1'b1}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_dig        <= 2'd3;
      r_shadow     <= 16'h0000;
      r_display    <= 16'h0000;
      load_pending <= 1'b0;
      nibble       <= 4'h0;
      an           <= {DIGITS{1'b1}};
      frame_done   <= 1'b0;
    end else begin
      if (en) begin
        an         <= w_an_next;
        frame_done <= w_frame_end;
        if (r_cnt == '0) begin
          nibble <= w_digit_nib;
        end
        if (w_slot_end) begin
          r_cnt <= '0;
          r_dig <= r_dig - 2'd1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_frame_end) begin
          r_display    <= r_shadow;
          load_pending <= 1'b0;
        end
      end else begin
        an         <= {DIGITS{1'b1}};
        frame_done <= 1'b0;
      end
      // A load coinciding with commit stays pending; commit used the old shadow.
      if (load) begin
        r_shadow     <= message;
        load_pending <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
